// File: rtl/tsu_pkg.sv
// Shared constants and types for the TX timestamp unit: EtherType values, PTP field
// offsets, the timestamp record layout and the per-frame parser state.
package tsu_pkg;

    localparam logic [15:0] ETH_TYPE_PTP  = 16'h88F7;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

    localparam int unsigned ETH_TYPE_OFS     = 12;
    localparam int unsigned VLAN_ETYPE_OFS   = 16;
    localparam int unsigned PTP_OFS_UNTAGGED = 14;
    localparam int unsigned PTP_OFS_TAGGED   = 18;
    localparam int unsigned PTP_SEQ_OFS      = 30;

    localparam logic [3:0] PTP_MSG_SYNC        = 4'h0;
    localparam logic [3:0] PTP_MSG_DELAY_REQ   = 4'h1;
    localparam logic [3:0] PTP_MSG_PDELAY_REQ  = 4'h2;
    localparam logic [3:0] PTP_MSG_PDELAY_RESP = 4'h3;
    localparam logic [3:0] PTP_MSG_FOLLOW_UP   = 4'h8;

    localparam int unsigned TS_REC_TS_W = 64;

    // Record layout at the default 64-bit RTC width.
    typedef struct packed {
        logic [3:0]             msg_type;
        logic [15:0]            seq_id;
        logic [TS_REC_TS_W-1:0] ts;
    } ts_rec_t;

    // Width-independent leading part of a record; the timestamp is appended.
    typedef struct packed {
        logic [3:0]  msg_type;
        logic [15:0] seq_id;
    } ts_hdr_t;

    typedef struct packed {
        logic [15:0] tpid;      // bytes 12-13: EtherType, or TPID when tagged
        logic [15:0] etype;     // bytes 16-17, captured only when tagged
        logic [3:0]  msg_type;
        logic [15:0] seq_id;
        logic        seq_done;  // last sequence-ID byte has been seen
    } parse_t;

    typedef enum logic [0:0] {
        StIdle,
        StFrame
    } frame_st_e;

    function automatic logic is_event_msg(input logic [3:0] msg_type);
        return msg_type <= PTP_MSG_PDELAY_RESP;
    endfunction

endpackage

// File: rtl/tsu_ts_fifo.sv
// Synchronous FIFO for timestamp records. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; the read data is forced to zero while empty.
module tsu_ts_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 84
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(Depth);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & ((count_q != CNT_FULL) | do_pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: data_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tsu_axis_tx_mw.sv
// Transmit-side timestamp unit: passes the MAC TX stream through untouched, stamps each
// frame at its first accepted beat and queues a record for every PTP event message.
module tsu_axis_tx_mw
    import tsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TS_WIDTH   = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  mac_axis_aclk,
    input  logic                  mac_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] mac_axis_tdata,
    input  logic                  mac_axis_tvalid,
    input  logic                  mac_axis_tlast,
    output logic                  mac_axis_tready,
    output logic [DATA_WIDTH-1:0] mac_axis_out_tdata,
    output logic                  mac_axis_out_tvalid,
    output logic                  mac_axis_out_tlast,
    input  logic                  mac_axis_out_tready,
    input  logic [TS_WIDTH-1:0]   rtc_timer_in,
    output logic [TS_WIDTH+19:0]  ts_tdata,
    output logic                  ts_tvalid,
    input  logic                  ts_tready,
    output logic [15:0]           ts_overflow_cnt
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned REC_W = TS_WIDTH + 20;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [5:0]  BEAT_MAX = 6'd63;

    frame_st_e            state_q, state_d;
    logic [5:0]           beat_cnt_q, beat_cnt_d;
    parse_t               parse_q, parse_d;
    logic [TS_WIDTH-1:0]  ts_lat_q, ts_lat_d;
    logic [15:0]          ovf_q, ovf_d;

    logic                 hs, sof, push, pop, full, vlan;
    logic [5:0]           beat_num;
    logic [IDX_W-1:0]     beat_base, ofs;
    logic [15:0]          eff_type;
    logic [7:0]           lane_byte [BYTES];
    logic [IDX_W-1:0]     lane_idx [BYTES];
    ts_hdr_t              rec_hdr;
    logic [CNT_W-1:0]     fifo_cnt;

    assign mac_axis_out_tdata  = mac_axis_tdata;
    assign mac_axis_out_tvalid = mac_axis_tvalid;
    assign mac_axis_out_tlast  = mac_axis_tlast;
    assign mac_axis_tready     = mac_axis_out_tready;

    assign hs        = mac_axis_tvalid & mac_axis_out_tready;
    assign sof       = hs & (state_q == StIdle);
    assign beat_num  = sof ? 6'd0 : beat_cnt_q;
    assign beat_base = IDX_W'(beat_num) * IDX_W'(BYTES);

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        assign lane_byte[k] = mac_axis_tdata[8*k +: 8];
        assign lane_idx[k]  = beat_base + IDX_W'(k);
    end

    // Lanes are walked in wire order so a tag seen in an early lane moves the PTP offset
    // for later lanes of the same beat.
    always_comb begin
        parse_d = sof ? '0 : parse_q;
        vlan    = 1'b0;
        ofs     = IDX_W'(PTP_OFS_UNTAGGED);
        if (hs) begin
            for (int k = 0; k < BYTES; k++) begin
                if (lane_idx[k] == IDX_W'(ETH_TYPE_OFS))     parse_d.tpid[15:8] = lane_byte[k];
                if (lane_idx[k] == IDX_W'(ETH_TYPE_OFS + 1)) parse_d.tpid[7:0]  = lane_byte[k];
                vlan = (parse_d.tpid == ETH_TYPE_VLAN);
                ofs  = vlan ? IDX_W'(PTP_OFS_TAGGED) : IDX_W'(PTP_OFS_UNTAGGED);
                if (vlan && lane_idx[k] == IDX_W'(VLAN_ETYPE_OFS)) begin
                    parse_d.etype[15:8] = lane_byte[k];
                end
                if (vlan && lane_idx[k] == IDX_W'(VLAN_ETYPE_OFS + 1)) begin
                    parse_d.etype[7:0] = lane_byte[k];
                end
                if (lane_idx[k] == ofs) parse_d.msg_type = lane_byte[k][3:0];
                if (lane_idx[k] == ofs + IDX_W'(PTP_SEQ_OFS)) begin
                    parse_d.seq_id[15:8] = lane_byte[k];
                end
                if (lane_idx[k] == ofs + IDX_W'(PTP_SEQ_OFS + 1)) begin
                    parse_d.seq_id[7:0] = lane_byte[k];
                    parse_d.seq_done    = 1'b1;
                end
            end
        end
    end

    assign eff_type = (parse_d.tpid == ETH_TYPE_VLAN) ? parse_d.etype : parse_d.tpid;
    assign push     = hs & mac_axis_tlast & (eff_type == ETH_TYPE_PTP)
                    & is_event_msg(parse_d.msg_type) & parse_d.seq_done;
    assign pop      = ts_tvalid & ts_tready;
    assign full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));

    assign rec_hdr.msg_type = parse_d.msg_type;
    assign rec_hdr.seq_id   = parse_d.seq_id;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        ts_lat_d   = sof ? rtc_timer_in : ts_lat_q;
        ovf_d      = ovf_q;
        if (hs) begin
            state_d = mac_axis_tlast ? StIdle : StFrame;
            if (sof) begin
                beat_cnt_d = 6'd1;
            end else if (beat_cnt_q != BEAT_MAX) begin
                beat_cnt_d = beat_cnt_q + 6'd1;
            end
        end
        if (push && full && !pop && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge mac_axis_aclk or negedge mac_axis_aresetn) begin
        if (!mac_axis_aresetn) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            parse_q    <= '0;
            ts_lat_q   <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            parse_q    <= parse_d;
            ts_lat_q   <= ts_lat_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ts_overflow_cnt = ovf_q;

    tsu_ts_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (REC_W)
    ) u_ts_fifo (
        .clk_i   (mac_axis_aclk),
        .rst_ni  (mac_axis_aresetn),
        .push_i  (push),
        .data_i  ({rec_hdr, ts_lat_d}),
        .pop_i   (ts_tready),
        .data_o  (ts_tdata),
        .valid_o (ts_tvalid),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_tsu_axis_tx_mw.sv
// Directed bench for tsu_axis_tx_mw: one 8-bit and one 64-bit instance share clock and reset.
module tb_tsu_axis_tx_mw;

    localparam int unsigned RW = 84;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]    s8_tdata, o8_tdata;
    logic          s8_tvalid, s8_tlast, s8_tready, o8_tvalid, o8_tlast, o8_tready;
    logic [63:0]   rtc8;
    logic [RW-1:0] ts8_tdata;
    logic          ts8_tvalid, ts8_tready;
    logic [15:0]   ovf8;

    logic [63:0]   s64_tdata, o64_tdata;
    logic          s64_tvalid, s64_tlast, s64_tready, o64_tvalid, o64_tlast, o64_tready;
    logic [63:0]   rtc64;
    logic [RW-1:0] ts64_tdata;
    logic          ts64_tvalid, ts64_tready;
    logic [15:0]   ovf64;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frm [128];
    int         flen;

    tsu_axis_tx_mw #(.DATA_WIDTH(8), .TS_WIDTH(64), .FIFO_DEPTH(4)) dut8 (
        .mac_axis_aclk       (clk),
        .mac_axis_aresetn    (rst_n),
        .mac_axis_tdata      (s8_tdata),
        .mac_axis_tvalid     (s8_tvalid),
        .mac_axis_tlast      (s8_tlast),
        .mac_axis_tready     (s8_tready),
        .mac_axis_out_tdata  (o8_tdata),
        .mac_axis_out_tvalid (o8_tvalid),
        .mac_axis_out_tlast  (o8_tlast),
        .mac_axis_out_tready (o8_tready),
        .rtc_timer_in        (rtc8),
        .ts_tdata            (ts8_tdata),
        .ts_tvalid           (ts8_tvalid),
        .ts_tready           (ts8_tready),
        .ts_overflow_cnt     (ovf8)
    );

    tsu_axis_tx_mw #(.DATA_WIDTH(64), .TS_WIDTH(64), .FIFO_DEPTH(4)) dut64 (
        .mac_axis_aclk       (clk),
        .mac_axis_aresetn    (rst_n),
        .mac_axis_tdata      (s64_tdata),
        .mac_axis_tvalid     (s64_tvalid),
        .mac_axis_tlast      (s64_tlast),
        .mac_axis_tready     (s64_tready),
        .mac_axis_out_tdata  (o64_tdata),
        .mac_axis_out_tvalid (o64_tvalid),
        .mac_axis_out_tlast  (o64_tlast),
        .mac_axis_out_tready (o64_tready),
        .rtc_timer_in        (rtc64),
        .ts_tdata            (ts64_tdata),
        .ts_tvalid           (ts64_tvalid),
        .ts_tready           (ts64_tready),
        .ts_overflow_cnt     (ovf64)
    );

    task automatic build_frame(input bit vlan, input logic [15:0] etype, input logic [3:0] msg,
                               input logic [15:0] seq, input int len);
        int p;
        for (int i = 0; i < 128; i++) frm[i] = 8'(i * 7 + 3);
        flen = len;
        if (vlan) begin
            frm[12] = 8'h81; frm[13] = 8'h00; frm[14] = 8'h00; frm[15] = 8'h05;
            frm[16] = etype[15:8]; frm[17] = etype[7:0];
            p = 18;
        end else begin
            frm[12] = etype[15:8]; frm[13] = etype[7:0];
            p = 14;
        end
        frm[p]      = {4'h0, msg};
        frm[p + 1]  = 8'h02;
        frm[p + 30] = seq[15:8];
        frm[p + 31] = seq[7:0];
    endtask

    // Called and returns at posedge+1; drops tvalid on return so a following send is
    // back-to-back.
    task automatic send8(input longint unsigned base, input bit toggle, input bit pop_last,
                         input bit no_last, output int pt_err);
        int i = 0;
        int cyc = 0;
        pt_err = 0;
        while (i < flen) begin
            s8_tdata   = frm[i];
            s8_tvalid  = 1'b1;
            s8_tlast   = !no_last && (i == flen - 1);
            o8_tready  = toggle ? ((cyc % 2) == 1) : 1'b1;
            rtc8       = base + 64'(cyc);
            ts8_tready = pop_last && (i == flen - 1) && o8_tready;
            #1;
            if (o8_tdata !== frm[i] || o8_tvalid !== 1'b1 || o8_tlast !== s8_tlast ||
                s8_tready !== o8_tready) pt_err++;
            @(posedge clk);
            #1;
            if (o8_tready) i++;
            cyc++;
        end
        s8_tvalid  = 1'b0;
        s8_tlast   = 1'b0;
        ts8_tready = 1'b0;
        o8_tready  = 1'b1;
    endtask

    task automatic send64(input longint unsigned base, output int pt_err);
        int nb = (flen + 7) / 8;
        logic [63:0] beat;
        pt_err = 0;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < 8; l++) beat[8*l +: 8] = (8 * b + l < flen) ? frm[8 * b + l] : 8'h00;
            s64_tdata  = beat;
            s64_tvalid = 1'b1;
            s64_tlast  = (b == nb - 1);
            rtc64      = base + 64'(b);
            #1;
            if (o64_tdata !== beat || o64_tvalid !== 1'b1 || o64_tlast !== s64_tlast ||
                s64_tready !== 1'b1) pt_err++;
            @(posedge clk);
            #1;
        end
        s64_tvalid = 1'b0;
        s64_tlast  = 1'b0;
    endtask

    task automatic pop8();
        ts8_tready = 1'b1;
        @(posedge clk);
        #1;
        ts8_tready = 1'b0;
    endtask

    task automatic pop64();
        ts64_tready = 1'b1;
        @(posedge clk);
        #1;
        ts64_tready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (ts8_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL rst_w8_tvalid: got %b expected 0", ts8_tvalid); end
        n_checks++; if (ts8_tdata !== '0) begin n_fail++;
            $display("FAIL rst_w8_tdata: got %h expected 0", ts8_tdata); end
        n_checks++; if (ovf8 !== 16'd0) begin n_fail++;
            $display("FAIL rst_w8_ovf: got %0d expected 0", ovf8); end
        n_checks++; if (ts64_tvalid !== 1'b0 || ts64_tdata !== '0 || ovf64 !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_w64: got v=%b d=%h o=%0d expected 0/0/0",
                     ts64_tvalid, ts64_tdata, ovf64);
        end
    endtask

    task automatic test_sync_w8();
        int pt;
        build_frame(1'b0, 16'h88F7, 4'h0, 16'h1234, 61);
        send8(64'd1000, 1'b0, 1'b0, 1'b0, pt);
        n_checks++; if (pt !== 0) begin n_fail++;
            $display("FAIL w8_passthrough: got %0d bad beats expected 0", pt); end
        n_checks++; if (ts8_tvalid !== 1'b1) begin n_fail++;
            $display("FAIL w8_sync_valid: got %b expected 1", ts8_tvalid); end
        n_checks++; if (ts8_tdata !== {4'h0, 16'h1234, 64'd1000}) begin n_fail++;
            $display("FAIL w8_sync_rec: got %h expected %h", ts8_tdata,
                     {4'h0, 16'h1234, 64'd1000}); end
        pop8();
        n_checks++; if (ts8_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL w8_sync_pop: got %b expected 0", ts8_tvalid); end
    endtask

    task automatic test_vlan_w64();
        int pt;
        build_frame(1'b1, 16'h88F7, 4'h1, 16'hBEEF, 60);
        send64(64'd6000, pt);
        n_checks++; if (pt !== 0) begin n_fail++;
            $display("FAIL w64_passthrough: got %0d bad beats expected 0", pt); end
        n_checks++; if (ts64_tvalid !== 1'b1 || ts64_tdata !== {4'h1, 16'hBEEF, 64'd6000}) begin
            n_fail++;
            $display("FAIL w64_vlan_rec: got v=%b d=%h expected 1 %h", ts64_tvalid, ts64_tdata,
                     {4'h1, 16'hBEEF, 64'd6000});
        end
        pop64();
        n_checks++; if (ts64_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL w64_vlan_pop: got %b expected 0", ts64_tvalid); end
    endtask

    task automatic test_no_record();
        int pt;
        build_frame(1'b0, 16'h0800, 4'h0, 16'h1234, 61);
        send8(64'd100, 1'b0, 1'b0, 1'b0, pt);
        n_checks++; if (ts8_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL norec_ipv4: got %b expected 0", ts8_tvalid); end
        build_frame(1'b0, 16'h88F7, 4'h8, 16'h1234, 61);
        send8(64'd200, 1'b0, 1'b0, 1'b0, pt);
        n_checks++; if (ts8_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL norec_followup: got %b expected 0", ts8_tvalid); end
        build_frame(1'b0, 16'h88F7, 4'h0, 16'h1234, 40);
        send8(64'd300, 1'b0, 1'b0, 1'b0, pt);
        n_checks++; if (ts8_tvalid !== 1'b0 || ovf8 !== 16'd0) begin n_fail++;
            $display("FAIL norec_truncated: got v=%b o=%0d expected 0/0", ts8_tvalid, ovf8); end
    endtask

    task automatic test_back_to_back();
        int pt;
        build_frame(1'b0, 16'h88F7, 4'h0, 16'h1111, 48);
        send64(64'd7000, pt);
        build_frame(1'b1, 16'h88F7, 4'h3, 16'h2222, 60);
        send64(64'd8000, pt);
        n_checks++; if (ts64_tdata !== {4'h0, 16'h1111, 64'd7000}) begin n_fail++;
            $display("FAIL b2b_first: got %h expected %h", ts64_tdata,
                     {4'h0, 16'h1111, 64'd7000}); end
        pop64();
        n_checks++; if (ts64_tdata !== {4'h3, 16'h2222, 64'd8000}) begin n_fail++;
            $display("FAIL b2b_second: got %h expected %h", ts64_tdata,
                     {4'h3, 16'h2222, 64'd8000}); end
        pop64();
        n_checks++; if (ts64_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL b2b_empty: got %b expected 0", ts64_tvalid); end
    endtask

    task automatic test_overflow();
        int pt;
        int exp_seq [4] = '{2, 3, 4, 7};
        for (int k = 1; k <= 6; k++) begin
            build_frame(1'b0, 16'h88F7, 4'h0, 16'(k), 46);
            send8(64'(k * 100), 1'b0, 1'b0, 1'b0, pt);
        end
        n_checks++; if (ovf8 !== 16'd2) begin n_fail++;
            $display("FAIL ovf_count: got %0d expected 2", ovf8); end
        n_checks++; if (ts8_tdata !== {4'h0, 16'd1, 64'd100}) begin n_fail++;
            $display("FAIL ovf_head: got %h expected %h", ts8_tdata, {4'h0, 16'd1, 64'd100}); end
        build_frame(1'b0, 16'h88F7, 4'h0, 16'd7, 46);
        send8(64'd700, 1'b0, 1'b1, 1'b0, pt);
        n_checks++; if (ovf8 !== 16'd2) begin n_fail++;
            $display("FAIL ovf_pushpop: got %0d expected 2", ovf8); end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (ts8_tvalid !== 1'b1 ||
                ts8_tdata !== {4'h0, 16'(exp_seq[j]), 64'(exp_seq[j] * 100)}) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got v=%b d=%h expected 1 %h", j, ts8_tvalid,
                         ts8_tdata, {4'h0, 16'(exp_seq[j]), 64'(exp_seq[j] * 100)});
            end
            pop8();
        end
        n_checks++; if (ts8_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL ovf_empty: got %b expected 0", ts8_tvalid); end
    endtask

    task automatic test_backpressure();
        int pt;
        build_frame(1'b0, 16'h88F7, 4'h0, 16'h0A0B, 61);
        send8(64'd2000, 1'b1, 1'b0, 1'b0, pt);
        n_checks++; if (pt !== 0) begin n_fail++;
            $display("FAIL bp_passthrough: got %0d bad beats expected 0", pt); end
        // First cycle has out_tready low, so the first accepted beat sees rtc 2001.
        n_checks++; if (ts8_tdata !== {4'h0, 16'h0A0B, 64'd2001}) begin n_fail++;
            $display("FAIL bp_stamp: got %h expected %h", ts8_tdata,
                     {4'h0, 16'h0A0B, 64'd2001}); end
        pop8();
    endtask

    task automatic test_reset_midframe();
        int pt;
        build_frame(1'b0, 16'h88F7, 4'h0, 16'h5555, 61);
        send8(64'd3000, 1'b0, 1'b0, 1'b0, pt);
        flen = 20;
        send8(64'd3100, 1'b0, 1'b0, 1'b1, pt);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ts8_tvalid !== 1'b0 || ts8_tdata !== '0) begin n_fail++;
            $display("FAIL midrst_fifo: got v=%b d=%h expected 0/0", ts8_tvalid, ts8_tdata); end
        n_checks++; if (ovf8 !== 16'd0) begin n_fail++;
            $display("FAIL midrst_ovf: got %0d expected 0", ovf8); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 41; i++) frm[i] = frm[i + 20];
        flen = 41;
        send8(64'd4000, 1'b0, 1'b0, 1'b0, pt);
        n_checks++; if (ts8_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL midrst_tail: got %b expected 0", ts8_tvalid); end
        build_frame(1'b0, 16'h88F7, 4'h0, 16'h6789, 61);
        send8(64'd5000, 1'b0, 1'b0, 1'b0, pt);
        n_checks++; if (ts8_tvalid !== 1'b1 || ts8_tdata !== {4'h0, 16'h6789, 64'd5000}) begin
            n_fail++;
            $display("FAIL midrst_next: got v=%b d=%h expected 1 %h", ts8_tvalid, ts8_tdata,
                     {4'h0, 16'h6789, 64'd5000});
        end
        pop8();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        s8_tdata = '0;  s8_tvalid = 1'b0;  s8_tlast = 1'b0;  o8_tready = 1'b1;
        rtc8 = '0;      ts8_tready = 1'b0;
        s64_tdata = '0; s64_tvalid = 1'b0; s64_tlast = 1'b0; o64_tready = 1'b1;
        rtc64 = '0;     ts64_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_sync_w8();
        test_vlan_w64();
        test_no_record();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
